// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer
// Control FSM for the fully-connected datapath. A pass walks G output-channel
// groups; for each group it issues K input/weight reads (one tile per cycle),
// drains the memory and PE pipeline, and then presents the group result to the
// downstream result path with a valid/ready handshake. This block has no
// arithmetic datapath.
//
// Ports:
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   start                 begin one layer pass (sampled only in IDLE)
//   busy, done            pass in progress / one-cycle end-of-pass pulse
//   inp_rd_en/addr        input memory read (addr = tile t)
//   wgt_rd_en/addr        weight read shared by all banks (addr = g*K + t)
//   bias_rd_en/addr       bias read on the first tile of each group (addr = g)
//   pe_valid/first/last   PE strobes aligned with the 1-cycle memory latency
//   acc_valid/group/ready group result handshake towards the result path

module fc_layer_sequencer #(
    parameter int ARRAY_N        = 16,
    parameter int ARRAY_M        = 2,
    parameter int INP_CHANNEL    = 96,
    parameter int OUTPUT_CHANNEL = 10,
    parameter int ADDR_WIDTH     = 10,
    parameter int PIPE_LAT       = 2,
    localparam int G             = OUTPUT_CHANNEL / ARRAY_M,
    localparam int GRP_W         = (G > 1) ? $clog2(G) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  inp_rd_en,
    output logic [ADDR_WIDTH-1:0] inp_rd_addr,
    output logic                  wgt_rd_en,
    output logic [ADDR_WIDTH-1:0] wgt_rd_addr,
    output logic                  bias_rd_en,
    output logic [ADDR_WIDTH-1:0] bias_rd_addr,
    output logic                  pe_valid,
    output logic                  pe_first,
    output logic                  pe_last,
    output logic                  acc_valid,
    output logic [GRP_W-1:0]      acc_group,
    input  logic                  acc_ready
);

    localparam int K  = INP_CHANNEL / ARRAY_N;
    localparam int TW = (K > 1) ? $clog2(K) : 1;
    localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    localparam logic [TW-1:0]    T_LAST = TW'(K - 1);
    localparam logic [GRP_W-1:0] G_LAST = GRP_W'(G - 1);
    localparam logic [DW-1:0]    D_LAST = DW'(PIPE_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state, state_next;
    logic [TW-1:0]           t, t_next;
    logic [GRP_W-1:0]        g, g_next;
    logic [DW-1:0]           d, d_next;
    // Weight addresses g*K+t are contiguous over the whole pass, so a plain
    // running counter replaces the multiply-add.
    logic [ADDR_WIDTH-1:0]   wa, wa_next;

    logic issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            t     <= '0;
            g     <= '0;
            d     <= '0;
            wa    <= '0;
        end else begin
            state <= state_next;
            t     <= t_next;
            g     <= g_next;
            d     <= d_next;
            wa    <= wa_next;
        end
    end

    always_comb begin
        state_next = state;
        t_next     = t;
        g_next     = g;
        d_next     = d;
        wa_next    = wa;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ISSUE;
                    t_next     = '0;
                    g_next     = '0;
                    wa_next    = '0;
                end
            end
            S_ISSUE: begin
                wa_next = wa + 1'b1;
                if (t == T_LAST) begin
                    state_next = S_DRAIN;
                    t_next     = '0;
                    d_next     = '0;
                end else begin
                    t_next = t + 1'b1;
                end
            end
            S_DRAIN: begin
                // 1 + PIPE_LAT cycles: memory latency plus PE pipeline.
                if (d == D_LAST) begin
                    state_next = S_WRITE;
                end else begin
                    d_next = d + 1'b1;
                end
            end
            S_WRITE: begin
                if (acc_ready) begin
                    if (g == G_LAST) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ISSUE;
                        g_next     = g + 1'b1;
                        t_next     = '0;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                g_next     = '0;
                wa_next    = '0;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign issue        = (state == S_ISSUE);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign inp_rd_en    = issue;
    assign wgt_rd_en    = issue;
    assign bias_rd_en   = issue && (t == '0);
    assign inp_rd_addr  = issue ? ADDR_WIDTH'(t) : '0;
    assign wgt_rd_addr  = issue ? wa : '0;
    assign bias_rd_addr = bias_rd_en ? ADDR_WIDTH'(g) : '0;
    assign acc_valid    = (state == S_WRITE);
    assign acc_group    = acc_valid ? g : '0;

    // PE strobes follow the read enables by the fixed 1-cycle memory latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            pe_valid <= 1'b0;
            pe_first <= 1'b0;
            pe_last  <= 1'b0;
        end else begin
            pe_valid <= issue;
            pe_first <= issue && (t == '0);
            pe_last  <= issue && (t == T_LAST);
        end
    end

endmodule
